// File: rtl/serial_word_rx_pkg.sv
// serial_word_rx_pkg
//   Shared definitions for the serial word receiver:
//     rx_state_t  - receiver FSM states (IDLE, SHIFT, FULL)
//     OVR_CNT_W   - width of the optional overrun counter
//     OVR_CNT_MAX - value at which the overrun counter saturates
package serial_word_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // no bits collected
        SHIFT = 2'd1,   // partial word collected
        FULL  = 2'd2    // complete word waiting for latch
    } rx_state_t;

    localparam int                   OVR_CNT_W   = 16;
    localparam logic [OVR_CNT_W-1:0] OVR_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det
//   Two-flop synchronizer for an asynchronous input followed by a
//   rising-edge detector producing a one-clk pulse.
//
//   Ports:
//     clk    in  system clock
//     n_rst  in  asynchronous active-low reset (all flops clear to 0)
//     din    in  asynchronous input
//     pulse  out one-clk pulse on each synchronized rising edge
//
//   After reset the synchronizer holds zeros that do not reflect the real
//   input. The detector is only armed once a genuine post-reset sample of
//   the input has been seen low, so a line held high through reset release
//   never looks like a rising edge.
module sync_edge_det (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic pulse
);

    logic [1:0] sync_reg;     // [0] first flop, [1] second flop
    logic       hist_reg;     // previous synchronized value
    logic [1:0] settle_reg;   // fills with ones as real samples reach sync_reg[1]
    logic       armed_reg;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_reg   <= 2'b00;
            hist_reg   <= 1'b0;
            settle_reg <= 2'b00;
            armed_reg  <= 1'b0;
        end else begin
            sync_reg   <= {sync_reg[0], din};
            hist_reg   <= sync_reg[1];
            settle_reg <= {settle_reg[0], 1'b1};
            if (settle_reg[1] && !sync_reg[1]) begin
                armed_reg <= 1'b1;
            end
        end
    end

    assign pulse = armed_reg & sync_reg[1] & ~hist_reg;

endmodule

// File: rtl/serial_word_rx.sv
// serial_word_rx
//   Receives a serial bit stream clocked by an external shift clock and
//   framed by an external latch strobe, and hands complete words to a
//   consumer with a valid/ready handshake.
//
//   Parameters:
//     NUM_BITS   word width (2..256)
//     SHIFT_MSB  0: first received bit ends in word bit 0
//                1: first received bit ends in word bit NUM_BITS-1
//
//   Ports:
//     clk          in  system clock
//     n_rst        in  asynchronous active-low reset
//     sclk_in      in  async shift clock, data taken on its rising edge
//     sdata_in     in  async serial data
//     latch_in     in  async word-boundary strobe, rising edge active
//     word_ready   in  consumer ready
//     word_out     out last accepted word
//     word_valid   out word_out holds an unconsumed word
//     bit_count    out bits shifted into the current word
//     frame_err    out one-clk pulse on a malformed word
//     overrun      out one-clk pulse when a complete word is dropped
//     overrun_cnt  out saturating overrun count (only with macro
//                      SERIAL_WORD_RX_OVERRUN_CNT_EN defined)
module serial_word_rx
    import serial_word_rx_pkg::*;
#(
    parameter int NUM_BITS  = 64,
    parameter int SHIFT_MSB = 0
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         sclk_in,
    input  logic                         sdata_in,
    input  logic                         latch_in,
    input  logic                         word_ready,
    output logic [NUM_BITS-1:0]          word_out,
    output logic                         word_valid,
    output logic [$clog2(NUM_BITS+1)-1:0] bit_count,
    output logic                         frame_err,
    output logic                         overrun
`ifdef SERIAL_WORD_RX_OVERRUN_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0]         overrun_cnt
`endif
);

    localparam int CW = $clog2(NUM_BITS+1);

    logic                sclk_edge;
    logic                latch_edge;
    logic [1:0]          sdata_sync_reg;

    rx_state_t           state_reg, state_next, state_mid;
    logic [CW-1:0]       cnt_reg, cnt_next, cnt_mid;
    logic [NUM_BITS-1:0] sr_reg, sr_next, sr_mid;
    logic [NUM_BITS-1:0] word_reg, word_next;
    logic                valid_reg, valid_next;
    logic                ferr_reg, ferr_next;
    logic                ovr_reg, ovr_next;
    logic                transfer;

    sync_edge_det u_sclk_det (
        .clk   (clk),
        .n_rst (n_rst),
        .din   (sclk_in),
        .pulse (sclk_edge)
    );

    sync_edge_det u_latch_det (
        .clk   (clk),
        .n_rst (n_rst),
        .din   (latch_in),
        .pulse (latch_edge)
    );

    // Data only needs to be stable; it shares the sclk synchronizer depth
    // so the sampled bit lines up with the detected shift edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sdata_sync_reg <= 2'b00;
        end else begin
            sdata_sync_reg <= {sdata_sync_reg[0], sdata_in};
        end
    end

    function automatic logic [NUM_BITS-1:0] shift_in(
        input logic [NUM_BITS-1:0] sr,
        input logic                b
    );
        if (SHIFT_MSB != 0) begin
            return {sr[NUM_BITS-2:0], b};
        end else begin
            return {b, sr[NUM_BITS-1:1]};
        end
    endfunction

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
            word_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sr_reg    <= sr_next;
            word_reg  <= word_next;
            valid_reg <= valid_next;
            ferr_reg  <= ferr_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_mid  = state_reg;
        cnt_mid    = cnt_reg;
        sr_mid     = sr_reg;
        transfer   = 1'b0;
        ferr_next  = 1'b0;
        ovr_next   = 1'b0;
        word_next  = word_reg;
        valid_next = valid_reg;

        // Latch is resolved first; a coincident shift edge then starts the
        // next word from an empty register.
        if (latch_edge) begin
            if (state_reg == FULL) begin
                transfer = 1'b1;
            end else begin
                ferr_next = 1'b1;
            end
            state_mid = IDLE;
            cnt_mid   = '0;
            sr_mid    = '0;
        end

        state_next = state_mid;
        cnt_next   = cnt_mid;
        sr_next    = sr_mid;

        if (sclk_edge) begin
            if (state_mid == FULL) begin
                // Extra bit: reported, ignored, word stays deliverable.
                ferr_next = 1'b1;
            end else begin
                sr_next    = shift_in(sr_mid, sdata_sync_reg[1]);
                cnt_next   = cnt_mid + CW'(1);
                state_next = (cnt_mid == CW'(NUM_BITS-1)) ? FULL : SHIFT;
            end
        end

        if (transfer) begin
            if (valid_reg && !word_ready) begin
                ovr_next = 1'b1;
            end else begin
                word_next  = sr_reg;
                valid_next = 1'b1;
            end
        end else if (valid_reg && word_ready) begin
            valid_next = 1'b0;
        end
    end

    assign word_out   = word_reg;
    assign word_valid = valid_reg;
    assign bit_count  = cnt_reg;
    assign frame_err  = ferr_reg;
    assign overrun    = ovr_reg;

`ifdef SERIAL_WORD_RX_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_reg;

    // Counts alongside the pulse so the count and pulse appear together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            ovr_cnt_reg <= '0;
        end else if (ovr_next && (ovr_cnt_reg != OVR_CNT_MAX)) begin
            ovr_cnt_reg <= ovr_cnt_reg + 1'b1;
        end
    end

    assign overrun_cnt = ovr_cnt_reg;
`endif

endmodule
